// File: rtl/pv_acc_pkg.sv
// Shared FSM encoding and accumulator width helpers for pv_accumulator.
// The DRAIN state is only reachable when the design is built with SUM_SQ_EN.
package pv_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pv_state_t;

    localparam int DEF_VAL_W      = 16;
    localparam int DEF_NPATH_LOG2 = 10;
    localparam int ACC_W          = DEF_VAL_W + DEF_NPATH_LOG2;
    localparam int SQ_W           = 2 * DEF_VAL_W + DEF_NPATH_LOG2;

    // Modules are parameterised, so they size their accumulators through these.
    function automatic int acc_width(input int valW, input int nPathLog2);
        return valW + nPathLog2;
    endfunction

    function automatic int sq_width(input int valW, input int nPathLog2);
        return 2 * valW + nPathLog2;
    endfunction

endpackage

// File: rtl/pv_square_stage.sv
// Registered squarer with a matching valid pipe; one cycle from sample to square.
// Only instantiated when pv_accumulator is built with SUM_SQ_EN.
module pv_square_stage #(
    parameter int VAL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [VAL_W-1:0]   i_val,
    output logic               o_valid,
    output logic [2*VAL_W-1:0] o_sq
);

    logic [2*VAL_W-1:0] w_ext;
    logic [2*VAL_W-1:0] r_sq;
    logic               r_valid;

    assign w_ext = {{VAL_W{1'b0}}, i_val};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sq    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sq <= w_ext * w_ext;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sq    = r_sq;

endmodule

// File: rtl/pv_accumulator.sv
// Sums 2**NPATH_LOG2 present-value samples and presents the mean to the host.
// Define SUM_SQ_EN to add a squaring pipeline, a DRAIN state and the mean_sq output.
module pv_accumulator
    import pv_acc_pkg::*;
#(
    parameter int VAL_W      = 16,
    parameter int NPATH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pv_valid,
    input  logic [VAL_W-1:0]      pv_val,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic [VAL_W-1:0]      mean,
    output logic [2*VAL_W-1:0]    mean_sq,
    output logic [NPATH_LOG2:0]   path_cnt
);

    localparam int ACC_BITS = acc_width(VAL_W, NPATH_LOG2);
    localparam int CNT_W    = NPATH_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << NPATH_LOG2) - 1);

    pv_state_t           r_state;
    logic                r_busy;
    logic                r_resultValid;
    logic [ACC_BITS-1:0] r_acc;
    logic [CNT_W-1:0]    r_pathCnt;
    logic [VAL_W-1:0]    r_mean;
    logic [ACC_BITS-1:0] w_accNext;
    logic                w_lastSample;

    assign w_accNext    = r_acc + ACC_BITS'(pv_val);
    assign w_lastSample = (r_pathCnt == LAST_CNT);

`ifdef SUM_SQ_EN
    localparam int SQ_BITS = sq_width(VAL_W, NPATH_LOG2);

    logic                w_accept;
    logic                w_sqValid;
    logic [2*VAL_W-1:0]  w_sq;
    logic [SQ_BITS-1:0]  w_sqAccNext;
    logic [SQ_BITS-1:0]  r_sqAcc;
    logic [2*VAL_W-1:0]  r_meanSq;

    assign w_accept    = (r_state == RUN) && pv_valid && !abort;
    assign w_sqAccNext = r_sqAcc + SQ_BITS'(w_sq);

    pv_square_stage #(.VAL_W(VAL_W)) u_square (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_accept),
        .i_val   (pv_val),
        .o_valid (w_sqValid),
        .o_sq    (w_sq)
    );

    // A stale square left in the pipe by an abort retires before any start can clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sqAcc <= '0;
        end else if (r_state == IDLE && start) begin
            r_sqAcc <= '0;
        end else if (w_sqValid) begin
            r_sqAcc <= w_sqAccNext;
        end
    end

    assign mean_sq = r_meanSq;
`else
    assign mean_sq = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_resultValid <= 1'b0;
            r_acc         <= '0;
            r_pathCnt     <= '0;
            r_mean        <= '0;
`ifdef SUM_SQ_EN
            r_meanSq      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc     <= '0;
                        r_pathCnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (pv_valid) begin
                        r_acc     <= w_accNext;
                        r_pathCnt <= r_pathCnt + CNT_W'(1);
                        if (w_lastSample) begin
`ifdef SUM_SQ_EN
                            r_state       <= DRAIN;
`else
                            r_mean        <= w_accNext[ACC_BITS-1:NPATH_LOG2];
                            r_busy        <= 1'b0;
                            r_resultValid <= 1'b1;
                            r_state       <= DONE;
`endif
                        end
                    end
                end
`ifdef SUM_SQ_EN
                DRAIN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_mean        <= r_acc[ACC_BITS-1:NPATH_LOG2];
                        r_meanSq      <= w_sqAccNext[SQ_BITS-1:NPATH_LOG2];
                        r_busy        <= 1'b0;
                        r_resultValid <= 1'b1;
                        r_state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (result_ack) begin
                        r_resultValid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_busy        <= 1'b0;
                    r_resultValid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_resultValid;
    assign mean         = r_mean;
    assign path_cnt     = r_pathCnt;

endmodule
